// File: rtl/mult_accumulator.sv
// mult_accumulator: sums LEN consecutive multiplier products into one group sum.
// Completed sums go into a small valid/ready output FIFO. The upstream product
// stream cannot be stalled, so a sum that arrives while the FIFO is full and
// nothing pops is dropped and drop_err is set.
module mult_accumulator #(
    parameter int DW    = 8,
    parameter int LEN   = 4,
    parameter int ACC_W = 12,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rstn,      // active-high asynchronous reset
    input  logic                    res_rdy,
    input  logic [DW-1:0]           res,
    input  logic                    clr,
    input  logic                    acc_ready,
    output logic                    acc_valid,
    output logic [ACC_W-1:0]        acc_sum,
    output logic [$clog2(LEN)-1:0]  grp_cnt,
    output logic                    drop_err
);

    localparam int CNT_W = $clog2(LEN);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    // Accumulator state
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_drop_err;

    // Output FIFO state
    logic [ACC_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    logic [ACC_W-1:0] w_sum;
    logic             w_take;
    logic             w_last;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_en;
    logic             w_drop;

    // Datapath and FIFO control decode
    always_comb begin
        w_sum   = r_acc + ACC_W'(res);
        w_take  = res_rdy & ~clr;
        w_last  = (r_cnt == CNT_LAST);
        w_push  = w_take & w_last;
        w_empty = (r_occ == '0);
        w_full  = (r_occ == OCC_FULL);
        w_pop   = ~w_empty & acc_ready;
        // When full, a same-edge pop frees the slot the write lands in
        // (write and read pointers coincide), so the push is still accepted.
        w_wr_en = w_push & (~w_full | w_pop);
        w_drop  = w_push & w_full & ~w_pop;
    end

    // Group accumulator and product counter; clr aborts the partial group
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (res_rdy) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Sticky drop flag: set on a lost sum, cleared only by clr or reset
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_drop_err <= 1'b0;
        end else if (clr) begin
            r_drop_err <= 1'b0;
        end else if (w_drop) begin
            r_drop_err <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care while unoccupied, so no reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_sum;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_wr_en && !w_pop) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (w_pop && !w_wr_en) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end
    end

    // Outputs come only from registers and the head entry
    always_comb begin
        acc_valid = ~w_empty;
        acc_sum   = w_empty ? '0 : r_mem[r_rd_ptr];
        grp_cnt   = r_cnt;
        drop_err  = r_drop_err;
    end

endmodule

// File: tb/tb_mult_accumulator.sv
// Testbench for mult_accumulator (default parameters). A queue of expected sums
// is filled as groups complete in the stimulus and drained as the DUT pops.
module tb_mult_accumulator;

    localparam int DW    = 8;
    localparam int LEN   = 4;
    localparam int ACC_W = 12;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rstn;
    logic             res_rdy;
    logic [DW-1:0]    res;
    logic             clr;
    logic             acc_ready;
    logic             acc_valid;
    logic [ACC_W-1:0] acc_sum;
    logic [1:0]       grp_cnt;
    logic             drop_err;

    int total;
    int bad;

    // Reference state
    int m_acc;
    int m_cnt;
    bit m_drop;
    int exp_q[$];

    mult_accumulator #(.DW(DW), .LEN(LEN), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .res_rdy   (res_rdy),
        .res       (res),
        .clr       (clr),
        .acc_ready (acc_ready),
        .acc_valid (acc_valid),
        .acc_sum   (acc_sum),
        .grp_cnt   (grp_cnt),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d @%0t", tag, got, want, $time);
        end
    endtask

    // Compare all outputs against the reference state
    task automatic check_outputs();
        check("acc_valid", 32'(acc_valid), 32'(exp_q.size() > 0));
        check("acc_sum", 32'(acc_sum), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
        check("grp_cnt", 32'(grp_cnt), 32'(m_cnt));
        check("drop_err", 32'(drop_err), 32'(m_drop));
    endtask

    // One clock: called at a falling edge, drives inputs, checks, advances the
    // reference for the coming rising edge, returns at the next falling edge.
    task automatic cycle(input bit rdy, input int v, input bit c, input bit rd);
        int sum;
        bit pop;
        res_rdy   = rdy;
        res       = DW'(v);
        clr       = c;
        acc_ready = rd;
        #1;
        check_outputs();
        pop = rd && (exp_q.size() > 0);
        if (pop) begin
            $display("pop sum=%0d", exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (c) begin
            m_acc  = 0;
            m_cnt  = 0;
            m_drop = 1'b0;
        end else if (rdy) begin
            if (m_cnt == LEN - 1) begin
                sum   = (m_acc + v) % (1 << ACC_W);
                m_acc = 0;
                m_cnt = 0;
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(sum);
                    $display("push sum=%0d", sum);
                end else begin
                    m_drop = 1'b1;
                    $display("drop sum=%0d", sum);
                end
            end else begin
                m_acc = (m_acc + v) % (1 << ACC_W);
                m_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic group(input int a, input int b, input int c, input int d, input bit rd);
        cycle(1'b1, a, 1'b0, rd);
        cycle(1'b1, b, 1'b0, rd);
        cycle(1'b1, c, 1'b0, rd);
        cycle(1'b1, d, 1'b0, rd);
    endtask

    task automatic idle(input bit rd);
        cycle(1'b0, 0, 1'b0, rd);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        m_acc     = 0;
        m_cnt     = 0;
        m_drop    = 1'b0;
        rstn      = 1'b1;
        res_rdy   = 1'b0;
        res       = '0;
        clr       = 1'b0;
        acc_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_valid", 32'(acc_valid), 32'd0);
        check("rst_sum", 32'(acc_sum), 32'd0);
        check("rst_cnt", 32'(grp_cnt), 32'd0);
        check("rst_drop", 32'(drop_err), 32'd0);

        // Basic group: 10+20+30+40, valid for exactly one cycle
        group(10, 20, 30, 40, 1'b1);
        check("sum100_valid", 32'(acc_valid), 32'd1);
        check("sum100", 32'(acc_sum), 32'd100);
        idle(1'b1);
        check("sum100_gone", 32'(acc_valid), 32'd0);

        // Largest products, then zeros, back to back
        group(225, 225, 225, 225, 1'b1);
        check("sum900", 32'(acc_sum), 32'd900);
        group(0, 0, 0, 0, 1'b1);
        idle(1'b1);

        // Backpressure: third group is dropped
        group(1, 1, 1, 1, 1'b0);
        group(2, 2, 2, 2, 1'b0);
        group(3, 3, 3, 3, 1'b0);
        check("bp_drop", 32'(drop_err), 32'd1);
        check("bp_head", 32'(acc_sum), 32'd4);
        idle(1'b1);
        check("bp_second", 32'(acc_sum), 32'd8);
        idle(1'b1);
        idle(1'b1);
        check("bp_empty", 32'(acc_valid), 32'd0);

        // Abort: 5, 6, then clr with a same-cycle product, then 1,1,1,1
        cycle(1'b1, 5, 1'b0, 1'b1);
        cycle(1'b1, 6, 1'b0, 1'b1);
        cycle(1'b1, 7, 1'b1, 1'b1);
        check("clr_cnt", 32'(grp_cnt), 32'd0);
        check("clr_drop", 32'(drop_err), 32'd0);
        group(1, 1, 1, 1, 1'b0);
        check("abort_sum", 32'(acc_sum), 32'd4);
        idle(1'b1);

        // Full FIFO with push and pop on the same edge
        group(1, 1, 1, 1, 1'b0);
        group(2, 2, 2, 2, 1'b0);
        cycle(1'b1, 3, 1'b0, 1'b0);
        cycle(1'b1, 3, 1'b0, 1'b0);
        cycle(1'b1, 3, 1'b0, 1'b0);
        cycle(1'b1, 3, 1'b0, 1'b1);
        check("pp_drop", 32'(drop_err), 32'd0);
        check("pp_head", 32'(acc_sum), 32'd8);
        idle(1'b1);
        check("pp_tail", 32'(acc_sum), 32'd12);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset mid-cycle with a queued sum and a partial group
        group(1, 1, 1, 1, 1'b0);
        cycle(1'b1, 1, 1'b0, 1'b0);
        cycle(1'b1, 1, 1'b0, 1'b0);
        res_rdy = 1'b0;
        #2;
        rstn = 1'b1;
        #1;
        check("arst_valid", 32'(acc_valid), 32'd0);
        check("arst_sum", 32'(acc_sum), 32'd0);
        check("arst_cnt", 32'(grp_cnt), 32'd0);
        check("arst_drop", 32'(drop_err), 32'd0);
        exp_q.delete();
        m_acc  = 0;
        m_cnt  = 0;
        m_drop = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        group(1, 2, 3, 4, 1'b1);
        check("arst_sum10", 32'(acc_sum), 32'd10);
        idle(1'b1);

        // Random stream with random backpressure and occasional clr
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 8), int'($urandom_range(0, 255)),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_accumulator.md
# mult_accumulator

Downstream consumer of the pipelined 4x4 multiplier's result stream. It takes each `res`/`res_rdy` product and sums LEN consecutive products into one group sum. Completed sums are queued in a small output FIFO with a valid/ready handshake. The multiplier has no backpressure, so this block is where stream-rate products are decoupled from a stalling consumer; overflow of the queue is flagged, never silently stalled.

## Interface
Parameters:
- `DW`, 8, product width; matches multiplier `res`.
- `LEN`, 4, number of products per group; range 2..16.
- `ACC_W`, 12, accumulator and sum width; must be ≥ DW + clog2(LEN). The defaults give a maximum sum of 1020, which fits.
- `DEPTH`, 2, number of output FIFO entries; range 2..8.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rstn` in 1: reset, asynchronous and active-high. Asserting `rstn`=1 clears all state immediately.
- `res_rdy` in 1: product strobe from the multiplier; one product per high cycle.
- `res` in DW: product value, sampled when `res_rdy`=1.
- `clr` in 1: synchronous abort of the partial group; also clears `drop_err`.
- `acc_ready` in 1: downstream ready.
- `acc_valid` out 1: FIFO non-empty.
- `acc_sum` out ACC_W: head-of-FIFO group sum; 0 when empty.
- `grp_cnt` out clog2(LEN): number of products in the current partial group.
- `drop_err` out 1: sticky; a completed sum was lost because the FIFO was full.

## Operation
- Accumulator `acc` (ACC_W bits) and counter `cnt` (0..LEN-1). `res` is zero-extended; all additions wrap modulo 2^ACC_W.
- On `res_rdy`=1 with `clr`=0:
  - If `cnt`<LEN-1: `acc` ← `acc`+`res`, `cnt` ← `cnt`+1.
  - If `cnt`=LEN-1: the group completes. `acc`+`res` is pushed to the FIFO, then `acc` ← 0 and `cnt` ← 0.
- `clr`=1 has priority over `res_rdy`:
  - `acc` ← 0, `cnt` ← 0, `drop_err` ← 0.
  - A same-cycle product is discarded.
  - FIFO contents and the output handshake are unaffected.
- Output FIFO: circular buffer with read and write pointers plus an occupancy count.
  - Pop when `acc_valid` & `acc_ready`.
  - A push and a pop in the same cycle are always accepted, including when the FIFO is full; occupancy is unchanged.
  - A push when full with no pop: the sum is dropped, FIFO contents are unchanged, and `drop_err` ← 1.
- `acc_sum` and `acc_valid` are driven from registers and the head entry, with no combinational path from `res` or `acc_ready`.
- Once `acc_valid` rises, `acc_sum` stays stable until it is popped.
- `grp_cnt` = `cnt`.

## Timing
- Reset values: `acc_valid`=0, `acc_sum`=0, `grp_cnt`=0, `drop_err`=0. FIFO empty, `acc`=0.
- Latency with the FIFO empty: the final product of a group is sampled at edge k; `acc_valid`=1 and `acc_sum` are correct in the cycle after edge k. Zero bubble.
- Throughput: accepts one product per cycle indefinitely. Back-to-back groups need no idle cycle.
- Pop: the head is removed at the edge where `acc_valid` & `acc_ready`. The next entry is presented in the following cycle; otherwise `acc_valid`=0 and `acc_sum`=0.
- Reset mid-group or with the FIFO occupied: everything returns to reset values asynchronously. The partial group and queued sums are lost; no error is raised.
- `drop_err` rises in the cycle after the dropping edge. It holds until `clr` or reset.

## Test plan
- Group sum: `res`=10,20,30,40 on 4 consecutive `res_rdy` cycles with `acc_ready`=1 → `acc_valid` for exactly 1 cycle, `acc_sum`=100, in the cycle after the 4th product.
- Width limit: 4 products of 225 (15×15), then 4 of 0 → sums 900 then 0. With `ACC_W`=10 and 4 products of 255 → wrapped sum 1020 mod 1024 = 1020; 5×255 with `LEN`=5 and `ACC_W`=10 → 251.
- Backpressure: `acc_ready`=0 and 3 groups (sums 4, 8, 12 from all-1, all-2, all-3 products) → FIFO holds 4 and 8, `drop_err`=1. Then `acc_ready`=1 → pops 4 then 8, then `acc_valid`=0.
- Full with simultaneous push and pop: FIFO full (4, 8), `acc_ready`=1 on the same edge the group of 12 completes → 4 popped, 12 accepted, `drop_err` stays 0.
- Abort: products 5, 6, then `clr` together with `res_rdy` (`res`=7), then 1, 1, 1, 1 → single sum 4, `grp_cnt`=0 after `clr`, `drop_err` cleared.
- Async reset: assert `rstn`=1 mid-clock with `grp_cnt`=2 and one queued sum → all outputs 0 before the next edge. After release, a fresh group of 1, 2, 3, 4 → sum 10.
